// File: rtl/mcs4_bus_master_if.sv
// MCS-4 nibble type and the shared bus bundle between the bus master and the ROM agents.
package mcs4;
    typedef logic [3:0] char_t;
endpackage

interface mcs4_bus_master_if;
    mcs4::char_t dbus_in;
    mcs4::char_t dbus_out;
    logic        sync;
    logic        cm_rom;
    logic        cl_rom;

    modport master (
        input  dbus_in,
        output dbus_out,
        output sync,
        output cm_rom,
        output cl_rom
    );

    modport slave (
        output dbus_in,
        input  dbus_out,
        input  sync,
        input  cm_rom,
        input  cl_rom
    );
endinterface

// File: rtl/mcs4_bus_master.sv
// MCS-4 processor-side bus initiator: 8-phase cycle, PC drive, OPR/OPA fetch, SRC/WRR/RDR ROM I/O.
module mcs4_bus_master #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    mcs4_bus_master_if.master   bus,
    input  logic                run,
    input  logic                pc_load,
    input  logic [11:0]         pc_value,
    input  logic [7:0]          src_addr,
    input  mcs4::char_t         wr_data,
    output logic [11:0]         pc,
    output logic [7:0]          instr,
    output logic                instr_valid,
    output mcs4::char_t         rd_data,
    output logic                rd_valid
);

    typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    phase_t      phase;
    mcs4::char_t opr_q;
    mcs4::char_t opa_q;
    logic        jump_pend;
    logic [11:0] jump_pc;
    logic        cl_rom_q;

    logic is_src, is_wrr, is_rdr;
    assign is_src = (opr_q == 4'h2) && opa_q[0];
    assign is_wrr = (opr_q == 4'hE) && (opa_q == 4'h2);
    assign is_rdr = (opr_q == 4'hE) && (opa_q == 4'hA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= IDLE;
            pc          <= RESET_PC;
            opr_q       <= '0;
            opa_q       <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            jump_pend   <= 1'b0;
            jump_pc     <= '0;
            cl_rom_q    <= 1'b1;
        end else begin
            cl_rom_q    <= 1'b0;
            instr_valid <= 1'b0;
            rd_valid    <= 1'b0;
            if (pc_load) begin
                jump_pend <= 1'b1;
                jump_pc   <= pc_value;
            end
            // Later assignments in the case override the pending-jump set above.
            case (phase)
                IDLE: begin
                    if (pc_load)        pc <= pc_value;
                    else if (jump_pend) pc <= jump_pc;
                    jump_pend <= 1'b0;
                    phase     <= run ? A1 : IDLE;
                end
                A1: phase <= A2;
                A2: phase <= A3;
                A3: phase <= M1;
                M1: begin
                    opr_q <= bus.dbus_in;
                    phase <= M2;
                end
                M2: begin
                    opa_q       <= bus.dbus_in;
                    instr       <= {opr_q, bus.dbus_in};
                    instr_valid <= 1'b1;
                    phase       <= X1;
                end
                X1: phase <= X2;
                X2: begin
                    if (is_rdr) begin
                        rd_data  <= bus.dbus_in;
                        rd_valid <= 1'b1;
                    end
                    phase <= X3;
                end
                X3: begin
                    if (pc_load)        pc <= pc_value;
                    else if (jump_pend) pc <= jump_pc;
                    else                pc <= pc + 12'd1;
                    jump_pend <= 1'b0;
                    phase     <= run ? A1 : IDLE;
                end
                default: phase <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.dbus_out = '0;
        bus.cm_rom   = 1'b0;
        case (phase)
            A1: bus.dbus_out = pc[3:0];
            A2: bus.dbus_out = pc[7:4];
            A3: bus.dbus_out = pc[11:8];
            M2: bus.cm_rom   = (opr_q == 4'hE);
            X2: begin
                if (is_src) begin
                    bus.dbus_out = src_addr[7:4];
                    bus.cm_rom   = 1'b1;
                end else if (is_wrr) begin
                    bus.dbus_out = wr_data;
                end
            end
            X3: if (is_src) bus.dbus_out = src_addr[3:0];
            default: ;
        endcase
    end

    assign bus.sync   = (phase == X3) || (phase == IDLE);
    assign bus.cl_rom = cl_rom_q;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Bench for mcs4_bus_master: small 4001 ROM model on the bus, fetch/I-O scoreboard, phase traces.
module tb_mcs4_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_value = '0;
    logic [7:0]  src_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [11:0] pc;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [3:0]  rd_data;
    logic        rd_valid;

    mcs4_bus_master_if bif ();

    mcs4_bus_master #(.RESET_PC(12'h000)) dut (
        .clk(clk), .rst(rst), .bus(bif), .run(run), .pc_load(pc_load),
        .pc_value(pc_value), .src_addr(src_addr), .wr_data(wr_data),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ROM agent model: tracks phase from sync, latches address, returns bytes and I/O.
    logic [7:0]  rom [4096];
    int          ph = 0;
    logic [11:0] maddr = '0;
    logic [7:0]  fetched = '0;
    logic        cm_m2 = 1'b0;
    logic [3:0]  io_out = '0;
    logic [3:0]  io_in = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0;
        end else begin
            if (bif.sync) ph <= 0;
            else          ph <= ph + 1;
            case (ph)
                0: maddr[3:0]  <= bif.dbus_out;
                1: maddr[7:4]  <= bif.dbus_out;
                2: maddr[11:8] <= bif.dbus_out;
                4: begin
                    fetched <= rom[maddr];
                    cm_m2   <= bif.cm_rom;
                end
                6: if (cm_m2 && fetched == 8'hE2) io_out <= bif.dbus_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        bif.dbus_in = 4'h0;
        if (!bif.sync) begin
            case (ph)
                3: bif.dbus_in = rom[maddr][7:4];
                4: bif.dbus_in = rom[maddr][3:0];
                6: if (fetched == 8'hEA) bif.dbus_in = io_in;
                default: ;
            endcase
        end
    end

    // Scoreboard monitor
    logic [7:0] exp_instr[$];
    logic [3:0] exp_rd[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                if (exp_instr.size() == 0) chk("instr_valid_unexpected", 1, 0);
                else chk("instr", instr, exp_instr.pop_front());
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("rd_valid_unexpected", 1, 0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
        end
    end

    // Per-cycle traces, index 0 = A1 ... 7 = X3
    logic [3:0]  tr_dbus [8];
    logic [11:0] tr_pc0;
    logic [7:0]  tr_sync, tr_cm, tr_iv, tr_rv;

    task automatic wait_a1();
        int n = 0;
        while (!(ph == 0 && !bif.sync)) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                $display("FAIL timeout_a1: got no A1 after %0d cycles expected A1", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic run_cycle(input int l0, input logic [11:0] v0,
                             input int l1, input logic [11:0] v1, input int stop_ph);
        wait_a1();
        tr_pc0 = pc;
        for (int i = 0; i < 8; i++) begin
            tr_dbus[i] = bif.dbus_out;
            tr_sync[i] = bif.sync;
            tr_cm[i]   = bif.cm_rom;
            tr_iv[i]   = instr_valid;
            tr_rv[i]   = rd_valid;
            pc_load = 1'b0;
            if (i == l0) begin pc_load = 1'b1; pc_value = v0; end
            if (i == l1) begin pc_load = 1'b1; pc_value = v1; end
            if (i == stop_ph) run = 1'b0;
            @(negedge clk);
        end
        pc_load = 1'b0;
    endtask

    task automatic load_idle(input logic [11:0] v);
        pc_load = 1'b1; pc_value = v;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h12; rom[12'h001] = 8'h34;
        rom[12'h010] = 8'hE2; rom[12'h011] = 8'hEA;
        rom[12'h012] = 8'h21; rom[12'h013] = 8'h20;
        rom[12'h014] = 8'hE2;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_sync", bif.sync, 1);
        chk("rst_dbus", bif.dbus_out, 0);
        chk("rst_cm", bif.cm_rom, 0);
        chk("rst_cl", bif.cl_rom, 1);
        chk("rst_pc", pc, 12'h000);
        chk("rst_instr", instr, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_valids", {instr_valid, rd_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cl_rom_release", bif.cl_rom, 0);
        chk("idle_pc", pc, 12'h000);

        // Straight-line fetch, run dropped in M1 of the second cycle
        exp_instr.push_back(8'h12);
        exp_instr.push_back(8'h34);
        run = 1'b1;
        run_cycle(-1, 0, -1, 0, -1);
        chk("c0_pc", tr_pc0, 12'h000);
        chk("c0_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'h000);
        chk("c0_sync", tr_sync, 8'b1000_0000);
        chk("c0_iv", tr_iv, 8'b0010_0000);
        chk("c0_cm", tr_cm, 8'h00);
        run_cycle(-1, 0, -1, 0, 3);
        chk("c1_pc", tr_pc0, 12'h001);
        chk("c1_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'h001);
        chk("c1_iv", tr_iv, 8'b0010_0000);
        chk("stop_sync", bif.sync, 1);
        chk("stop_pc", pc, 12'h002);
        repeat (3) @(negedge clk);
        chk("idle_hold_pc", pc, 12'h002);
        chk("idle_hold_sync", bif.sync, 1);

        // PC wrap, X3 jump, two loads in one cycle
        load_idle(12'hFFE);
        chk("idle_load_pc", pc, 12'hFFE);
        exp_instr.push_back(8'h00);
        exp_instr.push_back(8'h00);
        exp_instr.push_back(8'h12);
        exp_instr.push_back(8'h00);
        exp_instr.push_back(8'h00);
        run = 1'b1;
        run_cycle(-1, 0, -1, 0, -1);
        chk("ffe_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'hFFE);
        run_cycle(-1, 0, -1, 0, -1);
        chk("fff_pc", tr_pc0, 12'hFFF);
        chk("fff_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'hFFF);
        run_cycle(7, 12'h100, -1, 0, -1);
        chk("wrap_pc", tr_pc0, 12'h000);
        run_cycle(1, 12'h200, 4, 12'h300, -1);
        chk("x3_load_pc", tr_pc0, 12'h100);
        chk("x3_load_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'h100);
        chk("x3_load_a3", tr_dbus[2], 4'h1);
        run_cycle(-1, 0, -1, 0, 0);
        chk("last_load_pc", tr_pc0, 12'h300);
        chk("last_load_addr", {tr_dbus[2], tr_dbus[1], tr_dbus[0]}, 12'h300);
        chk("after_300_pc", pc, 12'h301);

        // WRR
        load_idle(12'h010);
        wr_data = 4'h9;
        exp_instr.push_back(8'hE2);
        run = 1'b1;
        run_cycle(-1, 0, -1, 0, 0);
        chk("wrr_cm", tr_cm, 8'b0001_0000);
        chk("wrr_x2", tr_dbus[6], 4'h9);
        chk("wrr_x1x3", {tr_dbus[5], tr_dbus[7]}, 8'h00);
        chk("wrr_mphase", {tr_dbus[3], tr_dbus[4]}, 8'h00);
        chk("wrr_io_out", io_out, 4'h9);
        chk("wrr_rv", tr_rv, 8'h00);

        // RDR
        io_in = 4'h5;
        exp_instr.push_back(8'hEA);
        exp_rd.push_back(4'h5);
        run = 1'b1;
        run_cycle(-1, 0, -1, 0, 0);
        chk("rdr_cm", tr_cm, 8'b0001_0000);
        chk("rdr_x2", tr_dbus[6], 4'h0);
        chk("rdr_x1x3", {tr_dbus[5], tr_dbus[7]}, 8'h00);
        chk("rdr_rv", tr_rv, 8'b1000_0000);
        chk("rdr_data", rd_data, 4'h5);

        // SRC then non-SRC 0x20
        src_addr = 8'hA7;
        exp_instr.push_back(8'h21);
        exp_instr.push_back(8'h20);
        run = 1'b1;
        run_cycle(-1, 0, -1, 0, -1);
        chk("src_cm", tr_cm, 8'b0100_0000);
        chk("src_x2", tr_dbus[6], 4'hA);
        chk("src_x3", tr_dbus[7], 4'h7);
        chk("src_x1", tr_dbus[5], 4'h0);
        run_cycle(-1, 0, -1, 0, 0);
        chk("nsrc_cm", tr_cm, 8'h00);
        chk("nsrc_x2x3", {tr_dbus[6], tr_dbus[7]}, 8'h00);
        chk("nsrc_pc", pc, 12'h014);

        // Reset pulsed in X2 of a WRR
        exp_instr.push_back(8'hE2);
        run = 1'b1;
        wait_a1();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        #1;
        chk("mid_rst_sync", bif.sync, 1);
        chk("mid_rst_dbus", bif.dbus_out, 0);
        chk("mid_rst_cm", bif.cm_rom, 0);
        chk("mid_rst_cl", bif.cl_rom, 1);
        chk("mid_rst_pc", pc, 12'h000);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_valids", {instr_valid, rd_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cl", bif.cl_rom, 0);
        repeat (10) @(negedge clk);
        chk("post_rst_pc", pc, 12'h000);
        chk("post_rst_io", io_out, 4'h9);

        chk("instr_queue_empty", exp_instr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
